// File: rtl/seq_div_pkg.sv
// Shared divider definitions: word width and FSM state encodings.
// Results are packed {HI=remainder, LO=quotient}, the same order MUL uses.
package seq_div_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/seq_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Produces one quotient bit per call.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] bmag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // One extra bit so the trial's sign is visible even for |B| = 2^(WIDTH-1)
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, bmag_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed divider: restoring division on magnitudes,
// then sign fix-up. Result is {remainder, quotient}.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] divresult
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic               dzo_q, dzo_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0] amag, bmag;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // |-2^(W-1)| wraps to itself, read back as unsigned 2^(W-1)
  assign amag = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign bmag = B[WIDTH-1] ? (~B + 1'b1) : B;

  assign quo_fix = (sa_q ^ sb_q) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = sa_q ? (~rem_q + 1'b1) : rem_q;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .bmag_i(bmag_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bmag_d  = bmag_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    dzo_d   = dzo_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d  = A[WIDTH-1];
          sb_d  = B[WIDTH-1];
          dzo_d = 1'b0;
          if (B == '0) begin
            dz_d    = 1'b1;
            rem_d   = A;
            quo_d   = '1;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            rem_d   = '0;
            quo_d   = amag;
            bmag_d  = bmag;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d   = dz_q ? {rem_q, quo_q} : {rem_fix, quo_fix};
        dzo_d   = dz_q;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bmag_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      dzo_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bmag_q  <= bmag_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      dzo_q   <= dzo_d;
      res_q   <= res_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dzo_q;
  assign divresult   = res_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: vector table, scoreboard,
// and hand-written reset / abort / ignored-start sequences.
module tb_seq_div;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] divresult;

  seq_div #(.WIDTH(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .divresult  (divresult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        dz;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   total;
  int   bad;
  logic [63:0] last_res;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] q, r;
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF)
      return {32'h0, 32'h80000000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] res, input logic dz);
    exp_t e;
    int   n;
    int   lat;
    e.res = res;
    e.dz  = dz;
    lat   = dz ? 1 : 33;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: no done after %0d cycles", n);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check("latency", 64'(n), 64'(lat));
      check("divresult", divresult, e.res);
      check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
      last_res = e.res;
      @(posedge clk);
      #1;
      check("done_pulse_1cyc", 64'(done), 64'd0);
      check("idle_after_done", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int cnt;
    total = 0;
    bad   = 0;
    clr   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    last_res = '0;

    vecs[0] = '{32'd100, 32'd7, 64'h00000002_0000000E, 1'b0};
    vecs[1] = '{-32'sd100, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0};
    vecs[2] = '{32'd100, -32'sd7, 64'h00000002_FFFFFFF2, 1'b0};
    vecs[3] = '{-32'sd100, -32'sd7, 64'hFFFFFFFE_0000000E, 1'b0};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
    vecs[5] = '{32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1};
    vecs[6] = '{32'd9, 32'd3, 64'h00000000_00000003, 1'b0};
    vecs[7] = '{32'h80000000, 32'd1, 64'h00000000_80000000, 1'b0};
    vecs[8] = '{32'h7FFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000000, 1'b0};
    vecs[9] = '{32'd0, 32'd5, 64'h0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_divresult", divresult, 64'd0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz);
      if (vecs[i].dz) begin
        repeat (3) @(posedge clk);
        #1;
        check("dz_held", 64'(div_by_zero), 64'd1);
      end
    end

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom_range(1, 1000);
      if (i[0]) rb = -rb;
      do_div(ra, rb, model(ra, rb), 1'b0);
    end

    // clr mid-operation: abort, no done
    @(negedge clk);
    A = 32'd100;
    B = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_divresult", divresult, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("abort_no_done", 64'(cnt), 64'd0);
    do_div(32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

    // start while busy is ignored
    @(negedge clk);
    A = 32'd100;
    B = 32'd7;
    start = 1'b1;
    sb.push_back('{64'h00000002_0000000E, 1'b0});
    @(negedge clk);
    start = 1'b0;
    A = 32'd55;
    B = 32'd55;
    repeat (3) @(negedge clk);
    A = 32'd1;
    B = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("held_while_busy", divresult, last_res);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        exp_t e;
        cnt++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ignored_start_res", divresult, e.res);
        end else begin
          total++;
          bad++;
          $display("FAIL extra_done: got result %h want none", divresult);
        end
      end
    end
    check("single_done", 64'(cnt), 64'd1);
    check("result_stable", divresult, 64'h00000002_0000000E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
